// File: rtl/inst_fetch_pkg.sv
// Shared CPU definitions: instruction/PC widths, fetch defaults, decode field positions.
package inst_fetch_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned PC_W   = 32;

  localparam logic [PC_W-1:0] PC_STEP          = PC_W'(4);
  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Instruction field positions consumed by decode
  localparam int unsigned OPCODE_LSB = 0;
  localparam int unsigned OPCODE_W   = 7;
  localparam int unsigned RD_LSB     = 7;
  localparam int unsigned FUNCT3_LSB = 12;
  localparam int unsigned FUNCT3_W   = 3;
  localparam int unsigned RS1_LSB    = 15;
  localparam int unsigned RS2_LSB    = 20;
  localparam int unsigned REG_W      = 5;
  localparam int unsigned FUNCT7_LSB = 25;
  localparam int unsigned FUNCT7_W   = 7;

  typedef struct packed {
    logic [INST_W-1:0] code;
    logic [PC_W-1:0]   pc;
  } fetch_entry_t;

  function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INST_W-1:0] inst);
    return inst[OPCODE_LSB +: OPCODE_W];
  endfunction

  function automatic logic [FUNCT3_W-1:0] funct3_of(input logic [INST_W-1:0] inst);
    return inst[FUNCT3_LSB +: FUNCT3_W];
  endfunction

  function automatic logic [FUNCT7_W-1:0] funct7_of(input logic [INST_W-1:0] inst);
    return inst[FUNCT7_LSB +: FUNCT7_W];
  endfunction

endpackage

// File: rtl/inst_rom.sv
// Instruction ROM with a registered read port; contents are preloaded into mem externally.
module inst_rom
  import inst_fetch_pkg::*;
#(
  parameter int unsigned DEPTH     = 64,
  parameter string       INIT_FILE = "inst.coe",
  parameter int unsigned AW        = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic [AW-1:0]     addr,
  output logic [INST_W-1:0] dout
);

  logic [INST_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    dout <= mem[addr];
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: PC, synchronous ROM read, and a 2-entry output FIFO with redirect.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned ROM_DEPTH = 64,
  parameter string       INIT_FILE = "inst.coe"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        inst_ready,
  output logic        inst_valid,
  output logic [31:0] inst_code,
  output logic [31:0] inst_pc
);

  localparam int unsigned     AW         = $clog2(ROM_DEPTH);
  localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);

  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   rd_pc;
  logic              rd_busy;
  logic [INST_W-1:0] rom_dout;

  // FIFO head lives directly in the output registers; tail is the second slot
  logic              tail_valid;
  fetch_entry_t      tail;

  logic              pop;
  logic              issue;
  logic [1:0]        occupancy;
  logic              head_valid_n;
  logic              tail_valid_n;
  fetch_entry_t      head_n;
  fetch_entry_t      tail_n;

  inst_rom #(
    .DEPTH    (ROM_DEPTH),
    .INIT_FILE(INIT_FILE),
    .AW       (AW)
  ) u_rom (
    .clk (clk),
    .addr(pc[AW+1:2]),
    .dout(rom_dout)
  );

  // Issue only if the read landing next edge is guaranteed a free slot
  always_comb begin
    pop       = inst_valid && inst_ready;
    occupancy = 2'(inst_valid) + 2'(tail_valid) + 2'(rd_busy);
    issue     = (occupancy - 2'(pop)) < 2'd2;
  end

  // Next FIFO contents: pop first, then accept the returning ROM word
  always_comb begin
    head_valid_n = inst_valid;
    head_n.code  = inst_code;
    head_n.pc    = inst_pc;
    tail_valid_n = tail_valid;
    tail_n       = tail;
    if (pop) begin
      head_valid_n = tail_valid;
      head_n       = tail;
      tail_valid_n = 1'b0;
      tail_n       = '0;
    end
    if (rd_busy) begin
      if (!head_valid_n) begin
        head_valid_n = 1'b1;
        head_n.code  = rom_dout;
        head_n.pc    = rd_pc;
      end else begin
        tail_valid_n = 1'b1;
        tail_n.code  = rom_dout;
        tail_n.pc    = rd_pc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= RESET_PC;
      rd_pc      <= '0;
      rd_busy    <= 1'b0;
      inst_valid <= 1'b0;
      inst_code  <= '0;
      inst_pc    <= '0;
      tail_valid <= 1'b0;
      tail       <= '0;
    end else if (redirect_valid) begin
      pc         <= redirect_pc & ALIGN_MASK;
      rd_busy    <= 1'b0;
      inst_valid <= 1'b0;
      inst_code  <= '0;
      inst_pc    <= '0;
      tail_valid <= 1'b0;
      tail       <= '0;
    end else begin
      inst_valid <= head_valid_n;
      inst_code  <= head_n.code;
      inst_pc    <= head_n.pc;
      tail_valid <= tail_valid_n;
      tail       <= tail_n;
      rd_busy    <= issue;
      if (issue) begin
        rd_pc <= pc;
        pc    <= pc + PC_STEP;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus a randomized stream model.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_ready = 1'b0;
  logic        inst_valid;
  logic [31:0] inst_code;
  logic [31:0] inst_pc;

  int          checks = 0;
  int          passed = 0;
  logic [31:0] exp_pc = '0;
  logic [64:0] obs;
  logic [64:0] ev;

  always #5 clk = ~clk;

  inst_fetch #(
    .RESET_PC (32'h0000_0000),
    .ROM_DEPTH(64),
    .INIT_FILE("")
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .inst_ready    (inst_ready),
    .inst_valid    (inst_valid),
    .inst_code     (inst_code),
    .inst_pc       (inst_pc)
  );

  // ROM image: word k holds 0x1000_0000 + k; addresses alias modulo 64 words
  function automatic logic [31:0] rom_word(input logic [31:0] pc);
    return 32'h1000_0000 + ((pc >> 2) % 32'd64);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    inst_ready = 1'b0;
    step();
    step();
    obs = {inst_valid, inst_pc, inst_code};
    checks++;
    if (obs !== 65'd0) $display("FAIL reset_outputs: got %h want %h", obs, 65'd0);
    else passed++;
    rst = 1'b0;
    step();
    obs = {inst_valid, inst_pc, inst_code};
    checks++;
    if (obs !== 65'd0) $display("FAIL reset_e0_idle: got %h want %h", obs, 65'd0);
    else passed++;
    step();
    obs = {inst_valid, inst_pc, inst_code};
    ev  = {1'b1, 32'h0000_0000, 32'h1000_0000};
    checks++;
    if (obs !== ev) $display("FAIL reset_first_word: got %h want %h", obs, ev);
    else passed++;
    exp_pc = 32'h0;
  endtask

  task automatic test_stream(input int n);
    inst_ready = 1'b1;
    for (int k = 0; k < n; k++) begin
      obs = {inst_valid, inst_pc, inst_code};
      ev  = {1'b1, exp_pc, rom_word(exp_pc)};
      checks++;
      if (obs !== ev) $display("FAIL stream[%0d]: got %h want %h", k, obs, ev);
      else passed++;
      exp_pc += 32'd4;
      step();
    end
  endtask

  task automatic test_stall();
    inst_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      obs = {inst_valid, inst_pc, inst_code};
      ev  = {1'b1, exp_pc, rom_word(exp_pc)};
      checks++;
      if (obs !== ev) $display("FAIL stall_hold[%0d]: got %h want %h", k, obs, ev);
      else passed++;
      step();
    end
    inst_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      obs = {inst_valid, inst_pc, inst_code};
      ev  = {1'b1, exp_pc, rom_word(exp_pc)};
      checks++;
      if (obs !== ev) $display("FAIL stall_resume[%0d]: got %h want %h", k, obs, ev);
      else passed++;
      exp_pc += 32'd4;
      step();
    end
  endtask

  task automatic test_redirect_full();
    inst_ready = 1'b0;
    step();
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0023;
    step();
    redirect_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      obs = {inst_valid, inst_pc, inst_code};
      checks++;
      if (obs !== 65'd0) $display("FAIL redir_full_gap[%0d]: got %h want %h", k, obs, 65'd0);
      else passed++;
      step();
    end
    obs = {inst_valid, inst_pc, inst_code};
    ev  = {1'b1, 32'h0000_0020, 32'h1000_0008};
    checks++;
    if (obs !== ev) $display("FAIL redir_full_target: got %h want %h", obs, ev);
    else passed++;
    exp_pc = 32'h0000_0020;
  endtask

  task automatic test_redirect_pop();
    inst_ready = 1'b1;
    obs = {inst_valid, inst_pc, inst_code};
    ev  = {1'b1, exp_pc, rom_word(exp_pc)};
    checks++;
    if (obs !== ev) $display("FAIL pop_head: got %h want %h", obs, ev);
    else passed++;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0040;
    step();
    redirect_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      obs = {inst_valid, inst_pc, inst_code};
      checks++;
      if (obs !== 65'd0) $display("FAIL pop_gap[%0d]: got %h want %h", k, obs, 65'd0);
      else passed++;
      step();
    end
    exp_pc = 32'h0000_0040;
    test_stream(4);
  endtask

  task automatic test_back_to_back();
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0010;
    step();
    redirect_pc    = 32'h0000_0080;
    step();
    redirect_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      obs = {inst_valid, inst_pc, inst_code};
      checks++;
      if (obs !== 65'd0) $display("FAIL b2b_gap[%0d]: got %h want %h", k, obs, 65'd0);
      else passed++;
      step();
    end
    exp_pc = 32'h0000_0080;
    test_stream(4);
  endtask

  task automatic test_alias();
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_00F0;
    step();
    redirect_valid = 1'b0;
    step();
    step();
    exp_pc = 32'h0000_00F0;
    for (int k = 0; k < 6; k++) begin
      obs = {inst_valid, inst_pc, inst_code};
      ev  = {1'b1, exp_pc, rom_word(exp_pc)};
      checks++;
      if (obs !== ev) $display("FAIL alias_stream[%0d]: got %h want %h", k, obs, ev);
      else passed++;
      if (exp_pc == 32'h0000_0100) begin
        checks++;
        if (inst_code !== 32'h1000_0000)
          $display("FAIL alias_word0: got %h want %h", inst_code, 32'h1000_0000);
        else passed++;
      end
      exp_pc += 32'd4;
      step();
    end
  endtask

  task automatic test_reset_mid();
    test_stream(3);
    #2;
    rst = 1'b1;
    #1;
    obs = {inst_valid, inst_pc, inst_code};
    checks++;
    if (obs !== 65'd0) $display("FAIL rst_async: got %h want %h", obs, 65'd0);
    else passed++;
    step();
    obs = {inst_valid, inst_pc, inst_code};
    checks++;
    if (obs !== 65'd0) $display("FAIL rst_hold: got %h want %h", obs, 65'd0);
    else passed++;
    #2;
    rst = 1'b0;
    step();
    obs = {inst_valid, inst_pc, inst_code};
    checks++;
    if (obs !== 65'd0) $display("FAIL rst_e0_idle: got %h want %h", obs, 65'd0);
    else passed++;
    step();
    exp_pc = 32'h0000_0000;
    test_stream(4);
  endtask

  // Random ready/redirect traffic against an in-order stream model
  task automatic test_random(input int n);
    int          blank;
    bit          vis;
    logic [31:0] tgt;
    blank = 0;
    for (int k = 0; k < n; k++) begin
      vis = (blank == 0);
      obs = {inst_valid, inst_pc, inst_code};
      ev  = vis ? {1'b1, exp_pc, rom_word(exp_pc)} : 65'd0;
      checks++;
      if (obs !== ev) $display("FAIL random[%0d]: got %h want %h", k, obs, ev);
      else passed++;
      if (blank > 0) blank--;
      inst_ready     = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      tgt            = $urandom;
      redirect_pc    = tgt;
      if (vis && inst_ready) exp_pc += 32'd4;
      if (redirect_valid) begin
        exp_pc = tgt & ~32'h3;
        blank  = 2;
      end
      step();
    end
    redirect_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) dut.u_rom.mem[6'(i)] = 32'h1000_0000 + 32'(i);
    test_reset();
    test_stream(20);
    test_stall();
    test_redirect_full();
    test_redirect_pop();
    test_back_to_back();
    test_alias();
    test_reset_mid();
    test_random(400);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
